uart_byte_rx: RTL
=================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clk cycles per serial bit; even, >= 4.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line (8N1, idle high); the far end of the core's Tx pin.
REQ-005 SHALL have port rd_en, input, 1, pop of the holding register; ignored when rx_valid=0.
REQ-006 SHALL have port rx_data, output, 8, holding-register byte; stable while rx_valid=1.
REQ-007 SHALL have port rx_valid, output, 1, high while the holding register is full.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port overrun, output, 1, sticky flag for a byte dropped while the holding register was full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: rx_s=0 -> START with bit counter cleared.
REQ-013 START: lasts CLKS_PER_BIT/2 cycles; at the last cycle, rx_s=0 -> DATA, rx_s=1 -> IDLE (glitch reject, no outputs).
REQ-014 DATA: samples rx_s on the last cycle of each CLKS_PER_BIT window; shifts LSB-first into the shift register; bit index 0..7; after bit 7 -> STOP.
REQ-015 STOP: samples rx_s on the last cycle of a CLKS_PER_BIT window; 1 -> byte complete, then IDLE; 0 -> frame_err=1 for the next cycle, byte discarded, then BREAK.
REQ-016 BREAK: stays until rx_s=1, then -> IDLE; no new frame is detected while in BREAK.
REQ-017 Byte complete with holding empty: rx_data<=shift register, rx_valid=1 from the next cycle.
REQ-018 rd_en with rx_valid=1 and no simultaneous completion: rx_valid=0 next cycle; rx_data holds its old value.
REQ-019 Completion in the same cycle as rd_en: new byte loaded, rx_valid stays 1, overrun unchanged.
REQ-020 Completion while full with no rd_en: new byte dropped; rx_data unchanged; overrun=1 next cycle.
REQ-021 overrun SHALL clear on the cycle after rd_en pops, unless REQ-020 fires in that same cycle.
REQ-022 Bit-period counter: width clog2(CLKS_PER_BIT); wraps 0..CLKS_PER_BIT-1; restarts at every state change.
REQ-023 Completion latency from the first clk edge seeing rx=0: 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles to the stop sample; rx_valid 1 cycle later.

Reset
REQ-024 rst=1 SHALL force: state IDLE, sync flops=1, counters=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no output; after release, a line still low SHALL be treated as a new start edge.
REQ-026 rd_en during rst SHALL have no effect.

Verification (CLKS_PER_BIT=8, 8-cycle bits)
REQ-027 Send 0xA5 -> rx_valid rises 79 cycles after rx falls; rx_data=0xA5; frame_err and overrun stay 0.
REQ-028 Pulse rx low for 2 cycles -> no rx_valid, no frame_err; FSM back in IDLE; a following 0x3C is received correctly.
REQ-029 Send 0x81 with stop bit 0, line held low 20 more cycles, then 0x55 -> one frame_err pulse; no byte for 0x81; rx_data=0x55.
REQ-030 Send 0x11 then 0x22 without rd_en -> rx_data=0x11, overrun=1; rd_en -> rx_valid=0 and overrun=0 next cycle.
REQ-031 Hold rd_en at the completion cycle of the second byte (0x11 then 0x22) -> rx_data=0x22, rx_valid stays 1, overrun=0.
REQ-032 Assert rst for 1 cycle during bit 4 of 0xF0, then send 0x0F -> no partial byte; rx_data=0x0F.

Source files
------------

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with one-byte holding register
// Oversamples the synchronized line and samples each bit on the last cycle of its window.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_rx_s;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic          w_last_bit;
    logic          w_last_half;
    logic [CW-1:0] w_cnt_next;
    logic          w_done;
    logic          w_pop;

    assign w_last_bit  = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_last_half = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign w_cnt_next  = w_last_bit ? '0 : r_cnt + CW'(1);
    assign w_done      = (r_state == STOP) && w_last_bit && r_rx_s;
    assign w_pop       = rd_en && r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_rx_s      <= r_sync1;
            r_frame_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state   <= START;
                        r_bit_idx <= 3'd0;
                    end
                end
                START: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Half-bit check re-centres sampling and rejects short glitches
                    if (w_last_half) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    r_cnt <= w_cnt_next;
                    if (w_last_bit) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    r_cnt <= w_cnt_next;
                    if (w_last_bit) begin
                        if (r_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state     <= BREAK;
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                BREAK: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // A pop in the completion cycle frees the slot for the incoming byte
            if (w_done && (!r_valid || w_pop)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_done) begin
                r_overrun <= 1'b1;
            end else if (w_pop) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
